// File: rtl/hand_scorer.sv
// Five-card hand classifier: collects five cards into a rank histogram, scans it
// one rank per cycle, reports a hand class, then requests a deck shuffle.
module hand_scorer #(
    parameter int MIN_PAIR_RANK = 11,
    parameter int WRAP_EN       = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             card_valid,
    output logic             card_ready,
    input  logic [3:0]       card_rank,
    input  logic [1:0]       card_suit,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [3:0]       value,
    output logic             err,
    output logic             shuffle,
    input  logic             shuffled,
    output logic [CNT_W-1:0] hands_cnt,
    output logic [CNT_W-1:0] win_cnt
);
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2, SHUF = 2'd3} state_t;

    localparam logic [3:0] MIN_PAIR_L = 4'(MIN_PAIR_RANK);
    localparam logic       WRAP_L     = (WRAP_EN != 0);

    state_t     state_r, state_nxt_s;
    logic [2:0] card_cnt_r;
    logic [2:0] hist_r [0:12];
    logic [1:0] first_suit_r;
    logic       flush_r, err_flag_r;
    logic [3:0] scan_idx_r;
    logic [1:0] pairs_r;
    logic [3:0] pair_rank_r;
    logic       trips_r, quads_r, straight_r;
    logic [2:0] run_r;
    logic       result_valid_r, err_r, shuffle_r;
    logic [3:0] value_r;
    logic [CNT_W-1:0] hands_cnt_r, win_cnt_r;

    logic       accept_s, legal_s, handshake_s, royal_set_s, straight_s, pair_pays_s;
    logic [2:0] cur_s, run_nxt_s;
    logic [3:0] class_s;

    assign card_ready   = rst_n & (state_r == IDLE);
    assign accept_s     = card_valid & (state_r == IDLE);
    assign legal_s      = (card_rank >= 4'd1) && (card_rank <= 4'd13);
    assign handshake_s  = (state_r == DONE) & result_valid_r & result_ready;
    assign cur_s        = hist_r[scan_idx_r];
    assign run_nxt_s    = (cur_s == 3'd1) ? run_r + 3'd1 : 3'd0;
    assign royal_set_s  = (hist_r[0] == 3'd1) && (hist_r[9] == 3'd1) && (hist_r[10] == 3'd1)
                        && (hist_r[11] == 3'd1) && (hist_r[12] == 3'd1);
    assign straight_s   = straight_r | (WRAP_L & royal_set_s);
    assign pair_pays_s  = (pair_rank_r == 4'd1) || (pair_rank_r >= MIN_PAIR_L);

    assign result_valid = result_valid_r;
    assign value        = value_r;
    assign err          = err_r;
    assign shuffle      = shuffle_r;
    assign hands_cnt    = hands_cnt_r;
    assign win_cnt      = win_cnt_r;

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && (card_cnt_r == 3'd4)) state_nxt_s = SCAN;
                else                                  state_nxt_s = IDLE;
            end
            SCAN: begin
                if (scan_idx_r == 4'd12) state_nxt_s = DONE;
                else                     state_nxt_s = SCAN;
            end
            DONE: begin
                if (handshake_s) state_nxt_s = SHUF;
                else             state_nxt_s = DONE;
            end
            SHUF: begin
                if (shuffled) state_nxt_s = IDLE;
                else          state_nxt_s = SHUF;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Hand classification from the scan accumulators, highest class first
    always_comb begin
        class_s = 4'd0;
        if (err_flag_r)                                 class_s = 4'd0;
        else if (flush_r && royal_set_s)                class_s = 4'd9;
        else if (flush_r && straight_s)                 class_s = 4'd8;
        else if (quads_r)                               class_s = 4'd7;
        else if (trips_r && (pairs_r == 2'd1))          class_s = 4'd6;
        else if (flush_r)                               class_s = 4'd5;
        else if (straight_s)                            class_s = 4'd4;
        else if (trips_r)                               class_s = 4'd3;
        else if (pairs_r == 2'd2)                       class_s = 4'd2;
        else if ((pairs_r == 2'd1) && pair_pays_s)      class_s = 4'd1;
        else                                            class_s = 4'd0;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_nxt_s;
    end

    // Card intake: histogram, flush and illegal-rank tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            card_cnt_r   <= 3'd0;
            first_suit_r <= 2'd0;
            flush_r      <= 1'b0;
            err_flag_r   <= 1'b0;
            for (int i = 0; i < 13; i++) hist_r[i] <= 3'd0;
        end else if (handshake_s) begin
            card_cnt_r <= 3'd0;
            flush_r    <= 1'b0;
            err_flag_r <= 1'b0;
            for (int i = 0; i < 13; i++) hist_r[i] <= 3'd0;
        end else if (accept_s) begin
            card_cnt_r <= (card_cnt_r == 3'd4) ? 3'd0 : card_cnt_r + 3'd1;
            err_flag_r <= err_flag_r | ~legal_s;
            if (card_cnt_r == 3'd0) begin
                first_suit_r <= card_suit;
                flush_r      <= 1'b1;
            end else begin
                flush_r <= flush_r & (card_suit == first_suit_r);
            end
            for (int i = 0; i < 13; i++) begin
                if (legal_s && (card_rank == 4'(i + 1))) hist_r[i] <= hist_r[i] + 3'd1;
                else                                      hist_r[i] <= hist_r[i];
            end
        end else begin
            card_cnt_r <= card_cnt_r;
        end
    end

    // Rank scan, one histogram entry per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_idx_r  <= 4'd0;
            pairs_r     <= 2'd0;
            pair_rank_r <= 4'd0;
            trips_r     <= 1'b0;
            quads_r     <= 1'b0;
            run_r       <= 3'd0;
            straight_r  <= 1'b0;
        end else if (handshake_s) begin
            scan_idx_r  <= 4'd0;
            pairs_r     <= 2'd0;
            pair_rank_r <= 4'd0;
            trips_r     <= 1'b0;
            quads_r     <= 1'b0;
            run_r       <= 3'd0;
            straight_r  <= 1'b0;
        end else if (state_r == SCAN) begin
            scan_idx_r <= (scan_idx_r == 4'd12) ? 4'd0 : scan_idx_r + 4'd1;
            run_r      <= run_nxt_s;
            straight_r <= straight_r | (run_nxt_s == 3'd5);
            trips_r    <= trips_r | (cur_s == 3'd3);
            quads_r    <= quads_r | (cur_s == 3'd4);
            if (cur_s == 3'd2) begin
                pairs_r     <= pairs_r + 2'd1;
                pair_rank_r <= scan_idx_r + 4'd1;
            end else begin
                pairs_r     <= pairs_r;
                pair_rank_r <= pair_rank_r;
            end
        end else begin
            scan_idx_r <= scan_idx_r;
        end
    end

    // Result presentation, statistics and shuffle request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_valid_r <= 1'b0;
            value_r        <= 4'd0;
            err_r          <= 1'b0;
            shuffle_r      <= 1'b0;
            hands_cnt_r    <= '0;
            win_cnt_r      <= '0;
        end else if (handshake_s) begin
            result_valid_r <= 1'b0;
            value_r        <= 4'd0;
            err_r          <= 1'b0;
            shuffle_r      <= 1'b1;
            if (hands_cnt_r != {CNT_W{1'b1}}) hands_cnt_r <= hands_cnt_r + 1'b1;
            else                              hands_cnt_r <= hands_cnt_r;
            if ((value_r != 4'd0) && (win_cnt_r != {CNT_W{1'b1}})) win_cnt_r <= win_cnt_r + 1'b1;
            else                                                     win_cnt_r <= win_cnt_r;
        end else if ((state_r == DONE) && !result_valid_r) begin
            result_valid_r <= 1'b1;
            value_r        <= class_s;
            err_r          <= err_flag_r;
        end else if ((state_r == SHUF) && shuffled) begin
            shuffle_r <= 1'b0;
        end else begin
            shuffle_r <= shuffle_r;
        end
    end
endmodule

// File: tb/tb_hand_scorer.sv
// Scoreboard bench for hand_scorer: a wrap-enabled and a wrap-disabled instance
// share stimulus; expected classes come from an independent hand model.
module tb_hand_scorer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        card_valid = 1'b0;
    logic [3:0]  card_rank = 4'd0;
    logic [1:0]  card_suit = 2'd0;
    logic        result_ready = 1'b0;
    logic        shuffled = 1'b0;

    logic        card_ready_w, result_valid_w, err_w, shuffle_w;
    logic [3:0]  value_w;
    logic [15:0] hands_w, win_w;
    logic        card_ready_n, result_valid_n, err_n, shuffle_n;
    logic [3:0]  value_n;
    logic [15:0] hands_n, win_n;

    int checks = 0;
    int failures = 0;
    int exp_hands = 0;
    int exp_win_w = 0;
    int exp_win_n = 0;

    typedef struct {
        logic [3:0] vw;
        logic [3:0] vn;
        logic       e;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    hand_scorer u_dut (
        .clk(clk), .rst_n(rst_n), .card_valid(card_valid), .card_ready(card_ready_w),
        .card_rank(card_rank), .card_suit(card_suit), .result_valid(result_valid_w),
        .result_ready(result_ready), .value(value_w), .err(err_w), .shuffle(shuffle_w),
        .shuffled(shuffled), .hands_cnt(hands_w), .win_cnt(win_w)
    );

    hand_scorer #(.WRAP_EN(0)) u_dut_nw (
        .clk(clk), .rst_n(rst_n), .card_valid(card_valid), .card_ready(card_ready_n),
        .card_rank(card_rank), .card_suit(card_suit), .result_valid(result_valid_n),
        .result_ready(result_ready), .value(value_n), .err(err_n), .shuffle(shuffle_n),
        .shuffled(shuffled), .hands_cnt(hands_n), .win_cnt(win_n)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] classify(input logic [4:0][3:0] r, input logic [4:0][1:0] s,
                                            input bit wrap);
        int cnt[16];
        int pairs = 0, trips = 0, quads = 0, pr = 0, mn = 99, mx = 0;
        bit fl = 1'b1, bad = 1'b0, distinct = 1'b1, royal, st;
        for (int v = 0; v < 16; v++) cnt[v] = 0;
        for (int i = 0; i < 5; i++) begin
            if (r[i] == 4'd0 || r[i] > 4'd13) bad = 1'b1;
            else cnt[r[i]]++;
            if (s[i] != s[0]) fl = 1'b0;
        end
        if (bad) return 4'd0;
        for (int v = 1; v <= 13; v++) begin
            if (cnt[v] == 2) begin pairs++; pr = v; end
            if (cnt[v] == 3) trips++;
            if (cnt[v] == 4) quads++;
            if (cnt[v] > 1) distinct = 1'b0;
            if (cnt[v] > 0 && v < mn) mn = v;
            if (cnt[v] > 0 && v > mx) mx = v;
        end
        royal = distinct && cnt[1] == 1 && cnt[10] == 1 && cnt[11] == 1 && cnt[12] == 1 && cnt[13] == 1;
        st = (distinct && (mx - mn == 4)) || (wrap && royal);
        if (fl && royal)                        return 4'd9;
        if (fl && st)                           return 4'd8;
        if (quads > 0)                          return 4'd7;
        if (trips > 0 && pairs == 1)            return 4'd6;
        if (fl)                                 return 4'd5;
        if (st)                                 return 4'd4;
        if (trips > 0)                          return 4'd3;
        if (pairs == 2)                         return 4'd2;
        if (pairs == 1 && (pr == 1 || pr >= 11)) return 4'd1;
        return 4'd0;
    endfunction

    task automatic run_hand(input logic [4:0][3:0] r, input logic [4:0][1:0] s,
                            input int rd, input int sd, input bit noise);
        exp_t e;
        bit early, held, sh, bad;
        for (int i = 0; i < 5; i++) begin
            card_rank  = r[i];
            card_suit  = s[i];
            card_valid = 1'b1;
            shuffled   = noise;
            @(posedge clk); #1;
        end
        card_valid = 1'b0;
        shuffled   = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) if (r[i] == 4'd0 || r[i] > 4'd13) bad = 1'b1;
        e.vw = classify(r, s, 1'b1);
        e.vn = classify(r, s, 1'b0);
        e.e  = bad;
        sb.push_back(e);

        early = 1'b0;
        for (int k = 0; k < 13; k++) begin
            result_ready = noise && (k < 11);
            shuffled     = noise && (k < 11);
            @(posedge clk); #1;
            if (result_valid_w || result_valid_n || card_ready_w) early = 1'b1;
        end
        result_ready = 1'b0;
        shuffled     = 1'b0;
        check_eq("no_early_valid", early, 0);
        @(posedge clk); #1;
        check_eq("valid_at_T14_w", result_valid_w, 1);
        check_eq("valid_at_T14_nw", result_valid_n, 1);

        held = 1'b1;
        for (int k = 0; k < rd; k++) begin
            @(posedge clk); #1;
            if (!result_valid_w || card_ready_w || value_w !== e.vw || err_w !== e.e) held = 1'b0;
        end
        if (rd > 0) check_eq("result_hold", held, 1);

        if (sb.size() == 0) begin
            check_eq("scoreboard_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            check_eq("value_w", value_w, e.vw);
            check_eq("value_nw", value_n, e.vn);
            check_eq("err_w", err_w, e.e);
            check_eq("err_nw", err_n, e.e);
        end

        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        exp_hands++;
        if (e.vw != 4'd0) exp_win_w++;
        if (e.vn != 4'd0) exp_win_n++;
        check_eq("hands_w", hands_w, exp_hands);
        check_eq("win_w", win_w, exp_win_w);
        check_eq("hands_nw", hands_n, exp_hands);
        check_eq("win_nw", win_n, exp_win_n);
        check_eq("shuffle_up", shuffle_w, 1);
        check_eq("valid_drop", result_valid_w, 0);

        sh = 1'b1;
        for (int k = 0; k < sd; k++) begin
            @(posedge clk); #1;
            if (!shuffle_w || card_ready_w) sh = 1'b0;
        end
        if (sd > 0) check_eq("shuffle_hold", sh, 1);
        shuffled = 1'b1;
        @(posedge clk); #1;
        shuffled = 1'b0;
        check_eq("shuffle_drop", shuffle_w, 0);
        check_eq("ready_back", card_ready_w, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", card_ready_w, 0);
        check_eq("rst_valid", result_valid_w, 0);
        check_eq("rst_hands", hands_w, 0);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_ready", card_ready_w, 1);
        @(posedge clk); #1;

        run_hand({4'd1, 4'd10, 4'd11, 4'd12, 4'd13}, {2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, 0, 0, 1'b0);
        run_hand({4'd10, 4'd11, 4'd12, 4'd13, 4'd1}, {2'd0, 2'd1, 2'd2, 2'd3, 2'd0}, 0, 0, 1'b0);
        run_hand({4'd3, 4'd3, 4'd3, 4'd9, 4'd9}, {2'd0, 2'd1, 2'd2, 2'd0, 2'd1}, 0, 0, 1'b0);
        run_hand({4'd10, 4'd10, 4'd4, 4'd5, 4'd7}, {2'd0, 2'd1, 2'd2, 2'd3, 2'd0}, 0, 0, 1'b0);
        run_hand({4'd1, 4'd1, 4'd4, 4'd5, 4'd7}, {2'd0, 2'd1, 2'd2, 2'd3, 2'd0}, 0, 0, 1'b0);
        run_hand({4'd2, 4'd14, 4'd5, 4'd6, 4'd7}, {2'd1, 2'd1, 2'd1, 2'd1, 2'd1}, 10, 0, 1'b0);
        run_hand({4'd4, 4'd5, 4'd6, 4'd7, 4'd8}, {2'd2, 2'd2, 2'd2, 2'd2, 2'd2}, 0, 4, 1'b0);
        run_hand({4'd9, 4'd9, 4'd9, 4'd9, 4'd2}, {2'd0, 2'd1, 2'd2, 2'd3, 2'd0}, 0, 0, 1'b0);
        run_hand({4'd2, 4'd5, 4'd8, 4'd11, 4'd13}, {2'd1, 2'd1, 2'd1, 2'd1, 2'd1}, 0, 0, 1'b0);
        run_hand({4'd6, 4'd6, 4'd6, 4'd2, 4'd3}, {2'd0, 2'd1, 2'd2, 2'd3, 2'd0}, 0, 0, 1'b0);
        run_hand({4'd11, 4'd11, 4'd2, 4'd4, 4'd6}, {2'd0, 2'd1, 2'd2, 2'd3, 2'd0}, 2, 1, 1'b1);
        run_hand({4'd2, 4'd3, 4'd4, 4'd5, 4'd6}, {2'd0, 2'd1, 2'd2, 2'd3, 2'd0}, 0, 0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            card_rank  = 4'(7 + i);
            card_suit  = 2'd0;
            card_valid = 1'b1;
            @(posedge clk); #1;
        end
        card_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        check_eq("midrst_ready", card_ready_w, 0);
        check_eq("midrst_hands", hands_w, 0);
        check_eq("midrst_win", win_w, 0);
        check_eq("midrst_shuffle", shuffle_w, 0);
        check_eq("midrst_value", value_w, 0);
        #3;
        rst_n = 1'b1;
        #1;
        check_eq("midrst_release_ready", card_ready_w, 1);
        exp_hands = 0;
        exp_win_w = 0;
        exp_win_n = 0;
        @(posedge clk); #1;
        run_hand({4'd2, 4'd2, 4'd5, 4'd5, 4'd9}, {2'd0, 2'd1, 2'd2, 2'd3, 2'd0}, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
